// File: rtl/rand_line_gen.sv
// Pulls five LCG words per line, scales them into endpoints and colour, and
// streams the programmed number of line commands over a valid/ready handshake.
module rand_line_gen #(
  parameter int unsigned WIDTH_D    = 32,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned COORD_BITS = 10,
  parameter int unsigned COLOR_BITS = 8,
  parameter int unsigned COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [COUNT_BITS-1:0] count,
  output logic                  busy,
  output logic                  done,
  output logic                  rand_next,
  input  logic                  rand_valid,
  input  logic [WIDTH_D-1:0]    rand_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COORD_BITS-1:0] out_x0,
  output logic [COORD_BITS-1:0] out_y0,
  output logic [COORD_BITS-1:0] out_x1,
  output logic [COORD_BITS-1:0] out_y1,
  output logic [COLOR_BITS-1:0] out_color
);

  localparam int unsigned PROD_W = 16 + COORD_BITS + 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StFetch  = 2'd1;
  localparam logic [1:0] StOutput = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [COUNT_BITS-1:0] remaining_q, remaining_d;
  logic [2:0]            index_q, index_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rand_next_q, rand_next_d;
  logic                  out_valid_q, out_valid_d;
  logic [COORD_BITS-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COLOR_BITS-1:0] color_q, color_d;

  // Scale the top 16 bits with a full-width product so nothing is lost before the shift.
  logic [15:0]           u;
  logic [PROD_W-1:0]     prod_x, prod_y;
  logic [COORD_BITS-1:0] scaled_x, scaled_y;
  logic [COLOR_BITS-1:0] scaled_c;
  logic                  unused_bits;

  assign u        = rand_data[WIDTH_D-1 -: 16];
  assign prod_x   = PROD_W'(u) * PROD_W'(SCREEN_W);
  assign prod_y   = PROD_W'(u) * PROD_W'(SCREEN_H);
  assign scaled_x = prod_x[16 +: COORD_BITS];
  assign scaled_y = prod_y[16 +: COORD_BITS];
  assign scaled_c = rand_data[WIDTH_D-1 -: COLOR_BITS];

  assign unused_bits = ^{rand_data[WIDTH_D-17:0], prod_x[15:0], prod_x[PROD_W-1],
                         prod_y[15:0], prod_y[PROD_W-1]};

  logic capture;
  // A word is fresh only when we did not request the next one last cycle.
  assign capture = rand_valid && !rand_next_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rand_next_d = 1'b0;
    out_valid_d = out_valid_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    color_d     = color_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d = count;
          index_d     = 3'd0;
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (capture) begin
          rand_next_d = 1'b1;
          index_d     = index_q + 3'd1;
          case (index_q)
            3'd0: x0_d = scaled_x;
            3'd1: y0_d = scaled_y;
            3'd2: x1_d = scaled_x;
            3'd3: y1_d = scaled_y;
            3'd4: begin
              color_d     = scaled_c;
              out_valid_d = 1'b1;
              state_d     = StOutput;
            end
            default: ;
          endcase
        end
      end
      StOutput: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          remaining_d = remaining_q - COUNT_BITS'(1);
          if (remaining_q == COUNT_BITS'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            index_d = 3'd0;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      index_q     <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rand_next_q <= 1'b0;
      out_valid_q <= 1'b0;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rand_next_q <= rand_next_d;
      out_valid_q <= out_valid_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rand_next = rand_next_q;
  assign out_valid = out_valid_q;
  assign out_x0    = x0_q;
  assign out_y0    = y0_q;
  assign out_x1    = x1_q;
  assign out_y1    = y1_q;
  assign out_color = color_q;

endmodule

// File: doc/rand_line_gen.md
Name: rand_line_gen

Overview:
- Consumer stage directly downstream of the LCG random generator (`rand`) in the line benchmark.
- On a start command, pulls five random words per line and scales them into x0, y0, x1, y1 and colour.
- Emits a programmed number of line commands to the line-drawing stage over a valid/ready handshake, then pulses done.

Parameters:
- WIDTH_D, 32, width of random word from generator.
- SCREEN_W, 640, x range; coordinates are 0..SCREEN_W-1.
- SCREEN_H, 480, y range; coordinates are 0..SCREEN_H-1.
- COORD_BITS, 10, width of each coordinate output.
- COLOR_BITS, 8, width of colour output.
- COUNT_BITS, 16, width of line count.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a batch; ignored while busy
- count  in  COUNT_BITS  number of lines in batch, sampled when start is accepted
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when batch finishes
- rand_next  out  1  request next random word (drives generator next)
- rand_valid  in  1  generator valid
- rand_data  in  WIDTH_D  generator data
- out_valid  out  1  line command valid
- out_ready  in  1  downstream accepts command
- out_x0, out_y0, out_x1, out_y1  out  COORD_BITS each  endpoints
- out_color  out  COLOR_BITS  line colour

Behaviour:
- Reset (async, any state): state IDLE; busy, done, rand_next, out_valid = 0; all out_* data = 0; remaining count = 0; field index = 0.
- States: IDLE, FETCH, OUTPUT.
- IDLE:
  - On start: latch count into remaining and set field index = 0.
  - If count == 0: pulse done next cycle, busy stays 0, remain in IDLE.
  - Otherwise: busy = 1, go to FETCH.
- FETCH, capture rule:
  - Capture when rand_valid == 1 and registered rand_next == 0.
  - On capture: store the scaled field selected by index, assert rand_next for exactly one cycle, increment index.
  - rand_next is never high on two consecutive cycles.
  - Generator handshake: valid falls the cycle after next, so the next capture occurs no earlier than 2 cycles after the previous one.
- Field order: 0 = x0, 1 = y0, 2 = x1, 3 = y1, 4 = colour.
- Scaling:
  - Let u = rand_data[WIDTH_D-1 : WIDTH_D-16] (upper 16 bits).
  - x = (u * SCREEN_W) >> 16; y = (u * SCREEN_H) >> 16.
  - Use a full-width product (16 + COORD_BITS + 1 bits); no truncation before the shift.
  - colour = rand_data[WIDTH_D-1 : WIDTH_D-COLOR_BITS].
- After capturing field 4: out_valid = 1 on the next cycle with all fields presented; go to OUTPUT.
- OUTPUT:
  - out_* held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid = 0 next cycle; remaining decrements.
  - If remaining was 1: done pulses 1 cycle, busy = 0, go to IDLE.
  - Otherwise: index = 0, go to FETCH.
- No prefetch during OUTPUT; rand_next stays low in IDLE and OUTPUT.
- start while busy: ignored, with no effect on count.
- rand_valid held low indefinitely: block waits in FETCH with no timeout.
- Reset mid-batch: immediate abort to IDLE, no done pulse; partial fields discarded.

Test Plan:
- Generator reset to default seed 0xdeadbeef; start, count = 1; out_ready = 1.
  - Expect first capture 0xdeadbeef → out_x0 = 556.
  - Second word 0x6115676A → out_y0 = 182.
  - Exactly 5 rand_next pulses, each separated by ≥2 cycles.
  - One out_valid beat, then done pulse, busy back to 0.
- count = 3, out_ready held 0 for 10 cycles on each beat.
  - out_* stable throughout each stall.
  - Exactly 3 transfers, 15 rand_next pulses total, single done.
- Forced rand_data = 0xFFFFFFFF → x = 639, y = 479, colour = 0xFF.
- Forced rand_data = 0x0000FFFF → x = 0, y = 0, colour = 0x00.
- start with count = 0 → done next cycle, busy never asserts, no rand_next, no out_valid.
- start again while busy → no effect.
- reset asserted asynchronously mid-FETCH (after 2 captures) → all outputs 0 immediately.
  - After release, a new start with count = 1 completes normally.
